// File: rtl/y86_regfile_mp.sv
// y86_regfile_mp: decode-stage register file for the Y86-64 core.
//   Two combinational read ports (srcA_i/srcB_i -> valA_o/valB_o) with an
//   optional same-cycle write-to-read bypass. Two write ports: E (execute) and
//   M (memory). M wins when both ports target the same register.
//   After reset an init sweep loads one register per cycle. ready_o rises when
//   the sweep finishes. err_o is a sticky flag for writes to illegal IDs.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   srcA_i/srcB_i           read IDs        valA_o/valB_o   read data (comb)
//   dstE_i/valE_i/weE_i     write port E    dstM_i/valM_i/weM_i  write port M
//   ready_o                 sweep done, writes accepted
//   err_o                   sticky illegal-write-ID flag
//   dbg_idx_i/dbg_val_o     stored-value peek, no bypass (comb)
module y86_regfile_mp #(
  parameter int unsigned          DATA_W   = 64,
  parameter int unsigned          ID_W     = 4,
  parameter int unsigned          NREG     = 15,
  parameter logic [ID_W-1:0]      RNONE    = ID_W'(15),
  parameter bit                   BYPASS   = 1'b1,
  parameter logic [ID_W-1:0]      RSP_ID   = ID_W'(4),
  parameter logic [DATA_W-1:0]    RSP_INIT = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ID_W-1:0]   srcA_i,
  input  logic [ID_W-1:0]   srcB_i,
  input  logic [ID_W-1:0]   dstE_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic              weE_i,
  input  logic [ID_W-1:0]   dstM_i,
  input  logic [DATA_W-1:0] valM_i,
  input  logic              weM_i,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o,
  output logic              ready_o,
  output logic              err_o,
  input  logic [ID_W-1:0]   dbg_idx_i,
  output logic [DATA_W-1:0] dbg_val_o
);

  // Array index width just wide enough for NREG entries.
  localparam int unsigned     IDX_W     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [ID_W:0]   NREG_W    = (ID_W+1)'(NREG);
  localparam logic [ID_W-1:0] NREG_LAST = ID_W'(NREG - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] regs [NREG];

  logic              wr_e, wr_m;
  logic              ill_e, ill_m;
  logic [DATA_W-1:0] init_val;

  // Legal register ID: not RNONE and inside the register array.
  function automatic logic id_legal(input logic [ID_W-1:0] id);
    return (id != RNONE) && ({1'b0, id} < NREG_W);
  endfunction

  // Write qualification; writes only count in RUN.
  always_comb begin
    wr_e     = (state_q == S_RUN) && weE_i && id_legal(dstE_i);
    wr_m     = (state_q == S_RUN) && weM_i && id_legal(dstM_i);
    ill_e    = (state_q == S_RUN) && weE_i && (dstE_i != RNONE) && !id_legal(dstE_i);
    ill_m    = (state_q == S_RUN) && weM_i && (dstM_i != RNONE) && !id_legal(dstM_i);
    init_val = (idx_q == RSP_ID) ? RSP_INIT : '0;
  end

  // Next-state and flag logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      S_INIT: begin
        // idx parks at NREG-1 on exit rather than wrapping.
        if (idx_q == NREG_LAST) begin
          state_d = S_RUN;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
      S_RUN: begin
        err_d = err_q | ill_e | ill_m;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
    ready_d = (state_d == S_RUN);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Register array: not cleared by reset, the sweep overwrites it.
  // M is assigned last so it wins a same-register collision.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      if (state_q == S_INIT) begin
        regs[IDX_W'(idx_q)] <= init_val;
      end else begin
        if (wr_e) regs[IDX_W'(dstE_i)] <= valE_i;
        if (wr_m) regs[IDX_W'(dstM_i)] <= valM_i;
      end
    end
  end

  // Read port: 0 during INIT or for illegal IDs; optional M-over-E bypass.
  function automatic logic [DATA_W-1:0] read_port(input logic [ID_W-1:0] src);
    logic [DATA_W-1:0] v;
    v = '0;
    if ((state_q == S_RUN) && id_legal(src)) begin
      v = regs[IDX_W'(src)];
      if (BYPASS) begin
        if (wr_m && (dstM_i == src)) begin
          v = valM_i;
        end else if (wr_e && (dstE_i == src)) begin
          v = valE_i;
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    valA_o = read_port(srcA_i);
    valB_o = read_port(srcB_i);
  end

  // Debug peek: stored value only.
  always_comb begin
    dbg_val_o = '0;
    if (id_legal(dbg_idx_i)) begin
      dbg_val_o = regs[IDX_W'(dbg_idx_i)];
    end
  end

  assign ready_o = ready_q;
  assign err_o   = err_q;

endmodule
